// File: rtl/store_rmw_sequencer.sv
// Store-path sequencer: SB/SH read-modify-write, SW direct write, size 00 completes with no access.
// Strobes and data are Moore-decoded from registered state and registered data only.
module store_rmw_sequencer #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       B,
  input  logic [1:0]        ss_control,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Handshake: start is a request level sampled only in IDLE; done pulses for one
  // cycle in DONE; mem_rd/mem_wr are single-cycle strobes and never overlap.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [31:0]       b_q;
  logic [1:0]        ss_q;
  logic [31:0]       wdata_q;
  logic [3:0]        cnt_q;
  logic              last_wait;

  assign last_wait = (state == S_WAIT) && (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (ss_control)
            2'b00:   state_n = S_DONE;
            2'b11:   state_n = S_WRITE;
            default: state_n = S_READ;
          endcase
        end
      end
      S_READ:  state_n = S_WAIT;
      S_WAIT:  if (last_wait) state_n = S_WRITE;
      S_WRITE: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      addr_hold_q <= '0;
      b_q         <= '0;
      ss_q        <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= addr;
            b_q    <= B;
            ss_q   <= ss_control;
            if (ss_control == 2'b11) wdata_q <= B;
          end
        end
        S_READ: begin
          cnt_q       <= 4'(MEM_LATENCY);
          addr_hold_q <= addr_q;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          // Lanes are fixed at the bottom of the word; the address never rotates them.
          if (cnt_q == 4'd1) begin
            if (ss_q == 2'b01) wdata_q <= {mem_rdata[31:8], b_q[7:0]};
            else               wdata_q <= {mem_rdata[31:16], b_q[15:0]};
          end
        end
        S_WRITE: addr_hold_q <= addr_q;
        default: ;
      endcase
    end
  end

  // mem_addr shows addr_q while accessing and otherwise keeps the last accessed address.
  assign mem_addr  = (state == S_READ || state == S_WRITE) ? addr_q : addr_hold_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = (state == S_READ);
  assign mem_wr    = (state == S_WRITE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Directed bench for store_rmw_sequencer: two instances (MEM_LATENCY 1 and 3) share stimulus.
module tb_store_rmw_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] b = '0;
  logic [1:0]  ss = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] ad1, wd1, ad3, wd3;
  logic        rd1, wr1, busy1, done1, rd3, wr3, busy3, done3;
  logic [2:0]  st1, st3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  store_rmw_sequencer #(.MEM_LATENCY(1), .ADDR_W(32)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .B(b),
    .ss_control(ss), .mem_rdata(mem_rdata), .mem_addr(ad1), .mem_rd(rd1),
    .mem_wr(wr1), .mem_wdata(wd1), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  store_rmw_sequencer #(.MEM_LATENCY(3), .ADDR_W(32)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .B(b),
    .ss_control(ss), .mem_rdata(mem_rdata), .mem_addr(ad3), .mem_rd(rd3),
    .mem_wr(wr3), .mem_wdata(wd3), .busy(busy3), .done(done3), .dbg_state(st3)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one sampling edge; returns in the first cycle after the sample.
  task automatic issue(input logic [31:0] a, input logic [31:0] bv, input logic [1:0] s);
    start = 1'b1;
    addr  = a;
    b     = bv;
    ss    = s;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    total++;
    if ({st1, busy1, done1, rd1, wr1, ad1, wd1} !== 71'd0) begin
      bad++;
      $display("FAIL reset_u1 got st=%0d busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h exp all zero",
               st1, busy1, done1, rd1, wr1, ad1, wd1);
    end
    total++;
    if ({st3, busy3, done3, rd3, wr3, ad3, wd3} !== 71'd0) begin
      bad++;
      $display("FAIL reset_u3 got st=%0d busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h exp all zero",
               st3, busy3, done3, rd3, wr3, ad3, wd3);
    end
    reset_n = 1'b1;
    repeat (2) step();
    total++;
    if ({busy1, busy3} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle got busy1=%b busy3=%b exp 00", busy1, busy3);
    end
  endtask

  // SB, latency 1: READ k1, WAIT k2, WRITE k3, DONE k4, IDLE k5.
  task automatic test_sb();
    logic [3:0] exp;
    mem_rdata = 32'h1122_3344;
    issue(32'h40, 32'h0000_00AB, 2'b01);
    for (int k = 1; k <= 5; k++) begin
      case (k)
        1: exp = 4'b1010;
        2: exp = 4'b1000;
        3: exp = 4'b1001;
        4: exp = 4'b1100;
        default: exp = 4'b0000;
      endcase
      total++;
      if ({busy1, done1, rd1, wr1} !== exp) begin
        bad++;
        $display("FAIL sb_ctl k=%0d got busy,done,rd,wr=%b exp %b", k, {busy1, done1, rd1, wr1}, exp);
      end
      if (k == 1) begin
        total++;
        if (ad1 !== 32'h40) begin
          bad++;
          $display("FAIL sb_rd_addr got %h exp 00000040", ad1);
        end
      end
      if (k == 3) begin
        total++;
        if (wd1 !== 32'h1122_33AB || ad1 !== 32'h40) begin
          bad++;
          $display("FAIL sb_write got wdata=%h addr=%h exp 112233ab 00000040", wd1, ad1);
        end
      end
      step();
    end
    repeat (4) step();
  endtask

  // SH, latency 3, address with nonzero low bits: data valid only on the last WAIT cycle (k4).
  task automatic test_sh();
    logic [3:0] exp;
    issue(32'h102, 32'hFFFF_BEEF, 2'b10);
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) mem_rdata = 32'hCAFE_0000;
      else        mem_rdata = 32'h0BAD_0000 | 32'($urandom_range(0, 65535));
      case (k)
        1: exp = 4'b1010;
        2, 3, 4: exp = 4'b1000;
        5: exp = 4'b1001;
        6: exp = 4'b1100;
        default: exp = 4'b0000;
      endcase
      total++;
      if ({busy3, done3, rd3, wr3} !== exp) begin
        bad++;
        $display("FAIL sh_ctl k=%0d got busy,done,rd,wr=%b exp %b", k, {busy3, done3, rd3, wr3}, exp);
      end
      if (k == 5) begin
        total++;
        if (wd3 !== 32'hCAFE_BEEF || ad3 !== 32'h102) begin
          bad++;
          $display("FAIL sh_write got wdata=%h addr=%h exp cafebeef 00000102", wd3, ad3);
        end
      end
      step();
    end
    repeat (2) step();
  endtask

  // SW on both instances: WRITE k1, DONE k2, IDLE k3; mem_rdata is ignored.
  task automatic test_sw();
    logic [3:0] exp;
    mem_rdata = 32'h1234_5678;
    issue(32'h300, 32'hDEAD_BEEF, 2'b11);
    for (int k = 1; k <= 3; k++) begin
      case (k)
        1: exp = 4'b1001;
        2: exp = 4'b1100;
        default: exp = 4'b0000;
      endcase
      total++;
      if ({busy1, done1, rd1, wr1} !== exp || {busy3, done3, rd3, wr3} !== exp) begin
        bad++;
        $display("FAIL sw_ctl k=%0d got u1=%b u3=%b exp %b", k,
                 {busy1, done1, rd1, wr1}, {busy3, done3, rd3, wr3}, exp);
      end
      if (k == 1) begin
        total++;
        if (wd1 !== 32'hDEAD_BEEF || ad1 !== 32'h300 || wd3 !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL sw_write got wd1=%h ad1=%h wd3=%h exp deadbeef 00000300 deadbeef", wd1, ad1, wd3);
        end
      end
      step();
    end
  endtask

  // Size 00: DONE k1, IDLE k2; no strobes and mem_addr keeps the previous access address.
  task automatic test_none();
    logic [3:0] exp;
    issue(32'h999, 32'h1357_9BDF, 2'b00);
    for (int k = 1; k <= 2; k++) begin
      exp = (k == 1) ? 4'b1100 : 4'b0000;
      total++;
      if ({busy1, done1, rd1, wr1} !== exp || {busy3, done3, rd3, wr3} !== exp) begin
        bad++;
        $display("FAIL none_ctl k=%0d got u1=%b u3=%b exp %b", k,
                 {busy1, done1, rd1, wr1}, {busy3, done3, rd3, wr3}, exp);
      end
      total++;
      if (ad1 !== 32'h300 || wd1 !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL none_hold k=%0d got addr=%h wdata=%h exp 00000300 deadbeef", k, ad1, wd1);
      end
      step();
    end
  endtask

  // start held high through an SB op on u1; B changes mid-operation.
  task automatic test_back_to_back();
    int first_writes;
    first_writes = 0;
    mem_rdata = 32'h1122_3344;
    issue(32'h80, 32'h0000_00AB, 2'b01);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) b = 32'h0000_00FF;
      if (k == 6) start = 1'b0;
      if (k <= 5 && wr1) begin
        first_writes++;
        total++;
        if (wd1 !== 32'h1122_33AB) begin
          bad++;
          $display("FAIL b2b_first_data k=%0d got %h exp 112233ab", k, wd1);
        end
      end
      if (k == 5) begin
        total++;
        if (st1 !== 3'd0 || busy1 !== 1'b0) begin
          bad++;
          $display("FAIL b2b_idle got state=%0d busy=%b exp 0 0", st1, busy1);
        end
      end
      if (k == 6) begin
        total++;
        if (rd1 !== 1'b1 || st1 !== 3'd1) begin
          bad++;
          $display("FAIL b2b_second_read got rd=%b state=%0d exp 1 1", rd1, st1);
        end
      end
      if (k == 8) begin
        total++;
        if (wr1 !== 1'b1 || wd1 !== 32'h1122_33FF) begin
          bad++;
          $display("FAIL b2b_second_write got wr=%b wdata=%h exp 1 112233ff", wr1, wd1);
        end
      end
      step();
    end
    total++;
    if (first_writes != 1) begin
      bad++;
      $display("FAIL b2b_write_count got %0d exp 1", first_writes);
    end
    repeat (8) step();
  endtask

  // Reset mid-WAIT aborts with no write; reset during WRITE drops mem_wr at once.
  task automatic test_reset_abort();
    issue(32'h200, 32'h0000_0055, 2'b01);
    step();
    total++;
    if (st3 !== 3'd2) begin
      bad++;
      $display("FAIL abort_pre_state got %0d exp 2", st3);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({st3, busy3, done3, rd3, wr3, ad3, wd3} !== 71'd0) begin
      bad++;
      $display("FAIL abort_async got st=%0d busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h exp all zero",
               st3, busy3, done3, rd3, wr3, ad3, wd3);
    end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (wr1 !== 1'b0 || wr3 !== 1'b0 || busy3 !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_write k=%0d got wr1=%b wr3=%b busy3=%b exp 0 0 0", k, wr1, wr3, busy3);
      end
      step();
    end
    issue(32'h44, 32'h0BAD_F00D, 2'b11);
    total++;
    if (wr1 !== 1'b1) begin
      bad++;
      $display("FAIL write_pre_reset got wr=%b exp 1", wr1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (wr1 !== 1'b0 || st1 !== 3'd0 || wd1 !== 32'd0) begin
      bad++;
      $display("FAIL write_async_drop got wr=%b state=%0d wdata=%h exp 0 0 0", wr1, st1, wd1);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_sw();
    test_none();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
